// File: rtl/sha1_padder.sv
// -----------------------------------------------------------------------------
// sha1_padder
//   Message-preparation stage in front of the SHA-1 core. Packs an incoming
//   byte stream big-endian into 512-bit blocks and applies SHA-1 padding:
//   a 0x80 byte, zero fill, then the 64-bit big-endian message bit length.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-low reset
//   in_data      message byte
//   in_valid     in_data is valid
//   in_last      with in_valid, final transfer of the message
//   in_empty     with in_valid, transfer carries no byte (zero-length message)
//   in_ready     transfer accepted on an edge where in_valid & in_ready
//   block_out    padded block, byte 0 at [511:504]
//   block_valid  block_out is complete and stable
//   block_ready  consumer takes the block on block_valid & block_ready
//   block_first  current block is the first block of a message
//   block_last   current block is the final, length-carrying block
// -----------------------------------------------------------------------------
module sha1_padder #(
  parameter int LEN_W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [7:0]   in_data,
  input  logic         in_valid,
  input  logic         in_last,
  input  logic         in_empty,
  output logic         in_ready,
  output logic [511:0] block_out,
  output logic         block_valid,
  input  logic         block_ready,
  output logic         block_first,
  output logic         block_last
);

  typedef enum logic [1:0] {
    FILL,
    PAD,
    LEN,
    EMIT
  } state_e;

  state_e             state_q;
  state_e             after_emit_q;  // where to resume once a non-final block leaves
  logic [511:0]       buf_q;
  logic [5:0]         ptr_q;         // next free byte slot
  logic [LEN_W-1:0]   count_q;       // message length in bytes, wraps silently
  logic               first_pend_q;
  logic               last_flag_q;

  logic [5:0]         ptr_d;
  logic [8:0]         slot_msb;
  logic [63:0]        bit_len;

  assign ptr_d    = ptr_q + 6'd1;
  // Byte slot p occupies [511-8p -: 8]; 511-8p == {~p, 3'b111}.
  assign slot_msb = {~ptr_q, 3'b111};
  assign bit_len  = 64'({count_q, 3'b000});

  assign block_out   = buf_q;
  assign block_valid = (state_q == EMIT);
  assign in_ready    = (state_q == FILL);
  assign block_first = first_pend_q;
  assign block_last  = last_flag_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: the block buffer is reset too, because block_out is a direct view
      // of it and must read zero during reset and after a mid-message abort.
      buf_q        <= '0;
      ptr_q        <= '0;
      count_q      <= '0;
      state_q      <= FILL;
      after_emit_q <= FILL;
      first_pend_q <= 1'b1;
      last_flag_q  <= 1'b0;
    end else begin
      // NOTE: all state uses non-blocking assignments so every branch below
      // sees the pre-edge values of ptr_q, count_q and state_q.
      case (state_q)
        FILL: begin
          if (in_valid) begin
            if (in_empty) begin
              // Empty transfer is always treated as the end of the message.
              state_q <= PAD;
            end else begin
              buf_q[slot_msb -: 8] <= in_data;
              ptr_q                <= ptr_d;
              count_q              <= count_q + LEN_W'(1);
              if (ptr_q == 6'd63) begin
                state_q      <= EMIT;
                after_emit_q <= in_last ? PAD : FILL;
              end else if (in_last) begin
                state_q <= PAD;
              end
            end
          end
        end

        PAD: begin
          buf_q[slot_msb -: 8] <= 8'h80;
          ptr_q                <= ptr_d;
          // No room left for the 8 length bytes: ship this block first.
          if (ptr_d == 6'd0 || ptr_d > 6'd56) begin
            state_q      <= EMIT;
            after_emit_q <= LEN;
          end else begin
            state_q <= LEN;
          end
        end

        LEN: begin
          buf_q[63:0] <= bit_len;
          last_flag_q <= 1'b1;
          state_q     <= EMIT;
        end

        EMIT: begin
          if (block_ready) begin
            buf_q        <= '0;
            ptr_q        <= '0;
            first_pend_q <= 1'b0;
            if (last_flag_q) begin
              last_flag_q  <= 1'b0;
              count_q      <= '0;
              first_pend_q <= 1'b1;
              state_q      <= FILL;
            end else begin
              state_q <= after_emit_q;
            end
          end
        end

        default: state_q <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_sha1_padder.sv
// -----------------------------------------------------------------------------
// tb_sha1_padder
//   Self-checking bench for sha1_padder. Inputs are driven 1 ns after the
//   rising edge, outputs sampled on the falling edge. Expected blocks come from
//   a byte-queue padding model (append 0x80, zero-fill to 56 mod 64, append
//   64-bit bit length, slice into 64-byte blocks).
// -----------------------------------------------------------------------------
module tb_sha1_padder;

  logic         clk = 1'b0;
  logic         reset;
  logic [7:0]   in_data;
  logic         in_valid;
  logic         in_last;
  logic         in_empty;
  logic         in_ready;
  logic [511:0] block_out;
  logic         block_valid;
  logic         block_ready;
  logic         block_first;
  logic         block_last;

  int errors = 0;
  int checks = 0;

  logic [511:0] got_blk[$];
  logic         got_first[$];
  logic         got_last[$];
  logic [511:0] exp_blk[$];

  bit rdy_force = 1'b1;
  bit rdy_val   = 1'b1;

  sha1_padder #(.LEN_W(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_last     (in_last),
    .in_empty    (in_empty),
    .in_ready    (in_ready),
    .block_out   (block_out),
    .block_valid (block_valid),
    .block_ready (block_ready),
    .block_first (block_first),
    .block_last  (block_last)
  );

  always #5 clk = ~clk;

  // Consumer readiness: forced or randomly throttled.
  always @(posedge clk) begin
    #1;
    block_ready = rdy_force ? rdy_val : ($urandom_range(0, 3) != 0);
  end

  // Record every block that will be taken on the next rising edge.
  always @(negedge clk) begin
    if (reset && block_valid && block_ready) begin
      got_blk.push_back(block_out);
      got_first.push_back(block_first);
      got_last.push_back(block_last);
    end
  end

  task automatic clear_queues();
    got_blk.delete();
    got_first.delete();
    got_last.delete();
    exp_blk.delete();
  endtask

  // Reference padding model.
  task automatic model(input logic [7:0] msg[$]);
    logic [7:0]   p[$];
    logic [63:0]  bl;
    logic [511:0] blk;
    p  = msg;
    bl = 64'(msg.size()) << 3;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    for (int k = 7; k >= 0; k--) p.push_back(bl[8*k +: 8]);
    for (int b = 0; b < p.size() / 64; b++) begin
      blk = '0;
      for (int j = 0; j < 64; j++) blk[511 - 8*j -: 8] = p[64*b + j];
      exp_blk.push_back(blk);
    end
  endtask

  // Drive a message; an empty queue sends a single in_empty transfer.
  task automatic send(input logic [7:0] msg[$], input bit with_last, input bit gaps);
    int n      = msg.size();
    int nx     = (n == 0) ? 1 : n;
    int i      = 0;
    int budget = 0;
    while (i < nx) begin
      @(posedge clk); #1;
      if (gaps && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
      end else begin
        in_valid = 1'b1;
        in_empty = (n == 0);
        in_data  = (n == 0) ? 8'($urandom) : msg[i];
        in_last  = with_last && (i == nx - 1);
      end
      @(negedge clk);
      if (in_valid && in_ready) begin
        i++;
      end else if (++budget > 5000) begin
        checks++;
        errors++;
        $display("FAIL send_timeout: got %0d accepted of %0d required", i, nx);
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_empty = 1'b0;
  endtask

  task automatic check_blocks(input string name);
    int budget = 0;
    while (got_blk.size() < exp_blk.size() && budget < 20000) begin
      @(negedge clk);
      budget++;
    end
    checks++;
    if (got_blk.size() != exp_blk.size()) begin
      errors++;
      $display("FAIL %s block_count: got %0d required %0d", name, got_blk.size(), exp_blk.size());
    end
    for (int b = 0; b < exp_blk.size() && b < got_blk.size(); b++) begin
      checks++;
      if (got_blk[b] !== exp_blk[b]) begin
        errors++;
        $display("FAIL %s blk%0d data: got %h required %h", name, b, got_blk[b], exp_blk[b]);
      end
      checks++;
      if (got_first[b] !== (b == 0)) begin
        errors++;
        $display("FAIL %s blk%0d first: got %b required %b", name, b, got_first[b], (b == 0));
      end
      checks++;
      if (got_last[b] !== (b == exp_blk.size() - 1)) begin
        errors++;
        $display("FAIL %s blk%0d last: got %b required %b", name, b, got_last[b],
                 (b == exp_blk.size() - 1));
      end
    end
    clear_queues();
  endtask

  task automatic run_msg(input string name, input logic [7:0] msg[$], input bit gaps);
    clear_queues();
    model(msg);
    send(msg, 1'b1, gaps);
    check_blocks(name);
  endtask

  task automatic abc_msg(output logic [7:0] msg[$]);
    msg = '{8'h61, 8'h62, 8'h63};
  endtask

  task automatic test_reset();
    #22;
    checks++;
    if (block_valid !== 1'b0 || in_ready !== 1'b1 || block_out !== '0 ||
        block_first !== 1'b1 || block_last !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got valid=%b ready=%b first=%b last=%b out_nz=%b required 0 1 1 0 0",
               block_valid, in_ready, block_first, block_last, |block_out);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (block_valid !== 1'b0 || in_ready !== 1'b1 || block_first !== 1'b1) begin
      errors++;
      $display("FAIL after_reset: got valid=%b ready=%b first=%b required 0 1 1",
               block_valid, in_ready, block_first);
    end
  endtask

  // "abc" against a literal block, plus the two-edge valid latency.
  task automatic test_abc(input string name);
    logic [7:0] msg[$];
    abc_msg(msg);
    clear_queues();
    exp_blk.push_back((512'h61626380 << 480) | 512'h18);
    rdy_force = 1'b1;
    rdy_val   = 1'b1;
    send(msg, 1'b1, 1'b0);
    checks++;
    if (block_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s valid_after_T: got %b required 0", name, block_valid);
    end
    @(posedge clk); #1;
    checks++;
    if (block_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s valid_after_T1: got %b required 0", name, block_valid);
    end
    @(posedge clk); #1;
    checks++;
    if (block_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s valid_after_T2: got %b required 1", name, block_valid);
    end
    check_blocks(name);
  endtask

  task automatic test_zero_len();
    logic [7:0] msg[$];
    run_msg("zero_len", msg, 1'b0);
  endtask

  task automatic test_len56();
    logic [7:0] msg[$];
    for (int i = 0; i < 56; i++) msg.push_back(8'h41);
    run_msg("len56", msg, 1'b0);
  endtask

  task automatic test_len64();
    logic [7:0] msg[$];
    for (int i = 0; i < 64; i++) msg.push_back(8'h00);
    run_msg("len64", msg, 1'b0);
  endtask

  task automatic test_random();
    logic [7:0] msg[$];
    int lens[10] = '{55, 63, 119, 128, 1, 0, 0, 0, 0, 0};
    rdy_force = 1'b0;
    for (int m = 0; m < 10; m++) begin
      msg.delete();
      if (m >= 5) lens[m] = $urandom_range(0, 200);
      for (int i = 0; i < lens[m]; i++) msg.push_back(8'($urandom));
      run_msg($sformatf("random%0d_len%0d", m, lens[m]), msg, 1'b1);
    end
    rdy_force = 1'b1;
  endtask

  task automatic test_backpressure();
    logic [7:0]   msg[$];
    logic [511:0] snap;
    logic         snap_first;
    logic         snap_last;
    int           budget = 0;
    abc_msg(msg);
    clear_queues();
    rdy_force = 1'b1;
    rdy_val   = 1'b0;
    @(posedge clk); #2;
    send(msg, 1'b1, 1'b0);
    while (!block_valid && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    snap       = block_out;
    snap_first = block_first;
    snap_last  = block_last;
    checks++;
    if (snap !== ((512'h61626380 << 480) | 512'h18) || snap_first !== 1'b1 || snap_last !== 1'b1) begin
      errors++;
      $display("FAIL bp_block: got first=%b last=%b data=%h required first=1 last=1 abc block",
               snap_first, snap_last, snap);
    end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if (block_valid !== 1'b1 || in_ready !== 1'b0 || block_out !== snap ||
          block_first !== snap_first || block_last !== snap_last) begin
        errors++;
        $display("FAIL bp_hold cycle%0d: got valid=%b in_ready=%b stable=%b required 1 0 1",
                 c, block_valid, in_ready,
                 (block_out === snap) && (block_first === snap_first) && (block_last === snap_last));
      end
    end
    rdy_val = 1'b1;
    @(posedge clk);   // block_ready rises just after this edge
    @(posedge clk);   // handshake edge
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || block_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: got in_ready=%b valid=%b required 1 0", in_ready, block_valid);
    end
    test_abc("bp_followup");
  endtask

  task automatic do_mid_reset(input string name);
    @(posedge clk); #3;
    reset = 1'b0;
    #1;
    checks++;
    if (block_valid !== 1'b0 || in_ready !== 1'b1 || block_out !== '0 || block_first !== 1'b1) begin
      errors++;
      $display("FAIL %s: got valid=%b in_ready=%b first=%b out_nz=%b required 0 1 1 0",
               name, block_valid, in_ready, block_first, |block_out);
    end
    @(negedge clk);
    reset = 1'b1;
    clear_queues();
  endtask

  task automatic test_reset_mid();
    logic [7:0] msg[$];
    rdy_force = 1'b1;
    rdy_val   = 1'b1;
    for (int i = 0; i < 20; i++) msg.push_back(8'($urandom_range(1, 255)));
    send(msg, 1'b0, 1'b0);
    do_mid_reset("reset_after_20");
    // Stall a full block in EMIT and reset underneath it.
    msg.delete();
    for (int i = 0; i < 64; i++) msg.push_back(8'h5a);
    rdy_val = 1'b0;
    @(posedge clk); #2;
    send(msg, 1'b0, 1'b0);
    @(negedge clk);
    do_mid_reset("reset_in_emit");
    rdy_val = 1'b1;
    test_abc("abc_after_reset");
  endtask

  initial begin
    reset       = 1'b0;
    in_data     = 8'h00;
    in_valid    = 1'b0;
    in_last     = 1'b0;
    in_empty    = 1'b0;
    block_ready = 1'b0;
    test_reset();
    test_abc("abc");
    test_zero_len();
    test_len56();
    test_len64();
    test_random();
    test_backpressure();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
